// File: rtl/pipelined_mac_pkg.sv
// Shared width and saturation helpers for the pipelined multiply-accumulate block.
package pipelined_mac_pkg;

  // Width used for the wide, sign-aware view of the sum when comparing against clamp limits.
  localparam int SAT_CALC_W = 64;

  // Width of the full-precision sum: the wider of product and addend, plus a carry bit.
  function automatic int mac_sum_w(input int a_w, input int b_w, input int c_w);
    int prod_w;
    prod_w = a_w + b_w;
    return ((prod_w > c_w) ? prod_w : c_w) + 1;
  endfunction

  // Largest representable result for the given output width and signedness.
  function automatic logic signed [SAT_CALC_W-1:0] sat_max(input int out_w, input int signed_mode);
    if (signed_mode != 0) begin
      return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    end
    return (64'sd1 <<< out_w) - 64'sd1;
  endfunction

  // Smallest representable result for the given output width and signedness.
  function automatic logic signed [SAT_CALC_W-1:0] sat_min(input int out_w, input int signed_mode);
    if (signed_mode != 0) begin
      return -(64'sd1 <<< (out_w - 1));
    end
    return 64'sd0;
  endfunction

endpackage

// File: rtl/pipelined_mac_skid_buffer.sv
// Generic one-entry valid/ready skid buffer. The upstream ready depends only on the
// registered full flag (and reset), so it never has a combinational path from downstream ready.
module pmac_skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_valid,
  output logic              up_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic              full
);

  logic              skid_full;
  logic [DATA_W-1:0] skid_data;

  assign up_ready = !skid_full && !reset;
  assign dn_valid = skid_full || (up_valid && up_ready);
  assign dn_data  = skid_full ? skid_data : up_data;
  assign full     = skid_full;

  // Fill the skid when an accepted op cannot move downstream; drain it as soon as downstream frees up.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_full <= 1'b0;
    end else if (skid_full && dn_ready) begin
      skid_full <= 1'b0;
    end else if (!skid_full && up_valid && up_ready && !dn_ready) begin
      skid_full <= 1'b1;
    end
  end

  // Capture the stalled op's payload; contents are meaningless while the skid is empty.
  always_ff @(posedge clk) begin
    if (!skid_full && up_valid && !dn_ready) begin
      skid_data <= up_data;
    end
  end

endmodule

// File: rtl/pipelined_mac.sv
// Three-stage multiply-accumulate pipeline (result = a*b + c) with valid/ready on both sides.
// Optional build macro MAC_SAT_EN: clamp the sum to the output range and add port out_sat;
// without it the result wraps to the low OUT_W bits.
module pipelined_mac
  import pipelined_mac_pkg::*;
#(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int C_W    = 16,
  parameter int OUT_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [C_W-1:0]   in_c,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_result,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MAC_SAT_EN
  output logic             out_sat,
`endif
  output logic             busy
);

  localparam int  PROD_W = A_W + B_W;
  localparam int  SUM_W  = mac_sum_w(A_W, B_W, C_W);
  localparam int  EXT_W  = SAT_CALC_W - SUM_W;
  localparam bit  SGN    = (SIGNED != 0);
`ifdef MAC_SAT_EN
  localparam logic signed [SAT_CALC_W-1:0] SAT_MAX = sat_max(OUT_W, SIGNED);
  localparam logic signed [SAT_CALC_W-1:0] SAT_MIN = sat_min(OUT_W, SIGNED);
`endif

  // Operand bundle carried through the skid buffer and stage 0.
  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
  } op_t;

  op_t in_op;
  op_t skid_op;
  op_t s0_op;
  logic skid_valid;
  logic skid_full;
  logic en;

  logic s0_valid;
  logic s1_valid;
  logic s2_valid;

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] s1_prod;
  logic [C_W-1:0]    s1_c;

  logic [SUM_W-1:0]              prod_x;
  logic [SUM_W-1:0]              c_x;
  logic [SUM_W-1:0]              sum;
  logic signed [SAT_CALC_W-1:0]  sum_x;
  logic [OUT_W-1:0]              next_result;
`ifdef MAC_SAT_EN
  logic                          next_sat;
`endif

  // Every stage moves together whenever the output slot is empty or being drained.
  assign en        = !s2_valid || out_ready;
  assign in_op     = '{a: in_a, b: in_b, c: in_c};
  assign out_valid = s2_valid;
  assign busy      = skid_full || s0_valid || s1_valid || s2_valid;

  pmac_skid_buffer #(
    .DATA_W($bits(op_t))
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .up_data  (in_op),
    .up_valid (in_valid),
    .up_ready (in_ready),
    .dn_data  (skid_op),
    .dn_valid (skid_valid),
    .dn_ready (en),
    .full     (skid_full)
  );

  // Extend operands to product width (sign or zero) and multiply; low PROD_W bits are exact.
  always_comb begin
    a_ext   = {{B_W{SGN & s0_op.a[A_W-1]}}, s0_op.a};
    b_ext   = {{A_W{SGN & s0_op.b[B_W-1]}}, s0_op.b};
    product = a_ext * b_ext;
  end

  // Form the full-precision sum and reduce it to the output width (wrap or clamp).
  always_comb begin
    prod_x      = {{(SUM_W-PROD_W){SGN & s1_prod[PROD_W-1]}}, s1_prod};
    c_x         = {{(SUM_W-C_W){SGN & s1_c[C_W-1]}}, s1_c};
    sum         = prod_x + c_x;
    sum_x       = {{EXT_W{SGN & sum[SUM_W-1]}}, sum};
    next_result = OUT_W'(sum_x);
`ifdef MAC_SAT_EN
    next_sat    = 1'b0;
    if (sum_x > SAT_MAX) begin
      next_result = SAT_MAX[OUT_W-1:0];
      next_sat    = 1'b1;
    end else if (sum_x < SAT_MIN) begin
      next_result = SAT_MIN[OUT_W-1:0];
      next_sat    = 1'b1;
    end
`endif
  end

  // Valid bits of S0/S1 advance on en and are cleared by reset, discarding in-flight ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else if (en) begin
      s0_valid <= skid_valid;
      s1_valid <= s0_valid;
    end
  end

  // Data registers of S0/S1 are not reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (en) begin
      s0_op   <= skid_op;
      s1_prod <= product;
      s1_c    <= s0_op.c;
    end
  end

  // Output stage: a new result replaces the departing one in the same cycle, so there is no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
`ifdef MAC_SAT_EN
      out_sat    <= 1'b0;
`endif
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= next_result;
`ifdef MAC_SAT_EN
        out_sat    <= next_sat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_mac.sv
// Directed self-checking bench for pipelined_mac: one unsigned and one signed instance share stimulus.
module tb_pipelined_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [15:0] in_c;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_u, in_ready_s;
  logic [15:0] out_result_u, out_result_s;
  logic        out_valid_u, out_valid_s;
  logic        busy_u, busy_s;
`ifdef MAC_SAT_EN
  logic        sat_u, sat_s;
  logic [31:0] sat_q_u[$];
`endif

  int check_count = 0;
  int fail_count  = 0;
  int cyc         = 0;
  int accept_cyc  = 0;
  int accept_count = 0;
  int valid_cycles = 0;

  logic [31:0] res_u[$];
  logic [31:0] res_s[$];
  logic [31:0] cyc_u[$];

  pipelined_mac #(.A_W(8), .B_W(8), .C_W(16), .OUT_W(16), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_valid(in_valid), .in_ready(in_ready_u), .out_result(out_result_u),
    .out_valid(out_valid_u), .out_ready(out_ready),
`ifdef MAC_SAT_EN
    .out_sat(sat_u),
`endif
    .busy(busy_u)
  );

  pipelined_mac #(.A_W(8), .B_W(8), .C_W(16), .OUT_W(16), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_valid(in_valid), .in_ready(in_ready_s), .out_result(out_result_s),
    .out_valid(out_valid_s), .out_ready(out_ready),
`ifdef MAC_SAT_EN
    .out_sat(sat_s),
`endif
    .busy(busy_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result transfer of both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && out_valid_u) valid_cycles++;
    if (!reset && out_valid_u && out_ready) begin
      res_u.push_back(32'(out_result_u));
      cyc_u.push_back(32'(cyc));
`ifdef MAC_SAT_EN
      sat_q_u.push_back(32'(sat_u));
`endif
    end
    if (!reset && out_valid_s && out_ready) res_s.push_back(32'(out_result_s));
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (got %0d, required finish)", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] qAt(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    int waited;
    waited = 0;
    in_a = a;
    in_b = b;
    in_c = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_u && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_in_time", 32'(waited < 100), 32'd1);
    accept_cyc = cyc;
    accept_count++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResults(input string tag, input int n);
    int waited;
    waited = 0;
    while (res_u.size() < n && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(tag, 32'(res_u.size() >= n), 32'd1);
  endtask

  task automatic clearQueues();
    res_u.delete();
    res_s.delete();
    cyc_u.delete();
`ifdef MAC_SAT_EN
    sat_q_u.delete();
`endif
    valid_cycles = 0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_c = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid_u), 32'd0);
    checkOutput("rst_busy", 32'(busy_u), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready_u), 32'd0);
    checkOutput("rst_out_result", 32'(out_result_u), 32'd0);
    checkOutput("rst_in_ready_s", 32'(in_ready_s), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready_u), 32'd1);

    // Single op: 3*4+5 = 17, latency 3, one valid cycle
    clearQueues();
    @(posedge clk);
    #1;
    applyStimulus(8'd3, 8'd4, 16'd5);
    repeat (8) @(negedge clk);
    checkOutput("single_count", 32'(res_u.size()), 32'd1);
    checkOutput("single_value", qAt(res_u, 0), 32'd17);
    checkOutput("single_value_s", qAt(res_s, 0), 32'd17);
    checkOutput("single_latency", qAt(cyc_u, 0) - 32'(accept_cyc), 32'd3);
    checkOutput("single_valid_cycles", 32'(valid_cycles), 32'd1);
    checkOutput("single_idle", 32'(busy_u), 32'd0);

    // Wrap: 255*255+0xFFFF = 0x1FE00; signed view -1*-1 + -1 = 0
    clearQueues();
    @(posedge clk);
    #1;
    applyStimulus(8'hFF, 8'hFF, 16'hFFFF);
    waitResults("wrap_timeout", 1);
    @(negedge clk);
`ifdef MAC_SAT_EN
    checkOutput("sat_value", qAt(res_u, 0), 32'h0000_FFFF);
    checkOutput("sat_flag", qAt(sat_q_u, 0), 32'd1);
`else
    checkOutput("wrap_value", qAt(res_u, 0), 32'h0000_FE00);
`endif
    checkOutput("wrap_value_s", qAt(res_s, 0), 32'h0000_0000);

    // Signed: -2*100 + -56 = -256; unsigned view 254*100+65480 = 0x16300
    clearQueues();
    @(posedge clk);
    #1;
    applyStimulus(8'hFE, 8'd100, 16'hFFC8);
    waitResults("signed_timeout", 1);
    @(negedge clk);
    checkOutput("signed_value_s", qAt(res_s, 0), 32'h0000_FF00);
`ifdef MAC_SAT_EN
    checkOutput("signed_unsigned_sat", qAt(res_u, 0), 32'h0000_FFFF);
`else
    checkOutput("signed_unsigned_wrap", qAt(res_u, 0), 32'h0000_6300);
`endif

    // Streaming 16 back-to-back ops: (i+1)*(i+2) + 3i
    clearQueues();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) applyStimulus(8'(i + 1), 8'(i + 2), 16'(3 * i));
    waitResults("stream_timeout", 16);
    repeat (5) @(negedge clk);
    checkOutput("stream_count", 32'(res_u.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("stream_val%0d", i), qAt(res_u, i), 32'((i + 1) * (i + 2) + 3 * i));
      checkOutput($sformatf("stream_val_s%0d", i), qAt(res_s, i), 32'((i + 1) * (i + 2) + 3 * i));
      checkOutput($sformatf("stream_cycle%0d", i), qAt(cyc_u, i), qAt(cyc_u, 0) + 32'(i));
    end

    // Backpressure: 10-cycle stall, then toggling out_ready; results 3*(i+20)+i = 4i+60
    clearQueues();
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 16; i++) applyStimulus(8'(i + 20), 8'd3, 16'(i));
      end
      begin
        int stall_start;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        stall_start = accept_count;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("bp_accepts_le4", 32'((accept_count - stall_start) <= 4), 32'd1);
        checkOutput("bp_in_ready_low", 32'(in_ready_u), 32'd0);
        checkOutput("bp_out_valid_held", 32'(out_valid_u), 32'd1);
        for (int k = 0; k < 10; k++) begin
          out_ready = ~out_ready;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    waitResults("bp_timeout", 16);
    repeat (5) @(negedge clk);
    checkOutput("bp_count", 32'(res_u.size()), 32'd16);
    checkOutput("bp_count_s", 32'(res_s.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("bp_val%0d", i), qAt(res_u, i), 32'(4 * i + 60));
    end

    // Reset with 3 ops in flight discards them
    clearQueues();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(8'd1, 8'd1, 16'd1);
    applyStimulus(8'd2, 8'd2, 16'd2);
    applyStimulus(8'd3, 8'd3, 16'd3);
    checkOutput("midrst_busy_before", 32'(busy_u), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(in_ready_u), 32'd0);
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid_u), 32'd0);
    checkOutput("midrst_busy", 32'(busy_u), 32'd0);
    checkOutput("midrst_out_result", 32'(out_result_u), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midrst_no_stale", 32'(res_u.size()), 32'd0);
    checkOutput("midrst_no_stale_s", 32'(res_s.size()), 32'd0);

    // Fresh op after reset: 5*6+7 = 37
    @(posedge clk);
    #1;
    applyStimulus(8'd5, 8'd6, 16'd7);
    waitResults("after_rst_timeout", 1);
    @(negedge clk);
    checkOutput("after_rst_value", qAt(res_u, 0), 32'd37);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
